mips_mc_controller: RTL and testbench

Parametrised multi-cycle MIPS control unit, the next-generation controller for the multi-cycle processor top. It drives the existing data path and adds several capabilities: a memory request/ready handshake for wait-state memories, an optional ADDI/J/BNE instruction subset, an illegal-instruction trap state, and cycle/retired-instruction performance counters. It sits between the data path (opcode, func, zero_flag) and external memory.

---
 rtl/mips_mc_controller.sv | 193 +++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_controller
// Brief    : Multi-cycle MIPS control unit with memory handshake, optional
//            ADDI/J/BNE decode, illegal-instruction trap and perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_controller #(
   parameter int unsigned MEM_HANDSHAKE = 1,
   parameter int unsigned SUPPORT_ADDI  = 1,
   parameter int unsigned SUPPORT_JUMP  = 1,
   parameter int unsigned SUPPORT_BNE   = 1,
   parameter int unsigned CNT_WIDTH     = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [5:0]           opcode,
   input  logic [5:0]           func,
   input  logic                 zero_flag,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_write,
   output logic                 iord,
   output logic                 pc_enable,
   output logic                 instr_write,
   output logic                 reg_write,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic                 mem_to_reg_sel,
   output logic                 reg_dest,
   output logic [1:0]           pc_source,
   output logic [2:0]           alu_control,
   output logic                 illegal_op,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR  = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6,  S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,  S_BNEEX   = 4'd9,  S_ADDIEX  = 4'd10, S_ADDIWB = 4'd11,
      S_JEX     = 4'd12, S_TRAP    = 4'd13
   } state_t;

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_BNE   = 6'b000101;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_J     = 6'b000010;
   localparam logic [2:0] c_ALU_ADD  = 3'b010;
   localparam logic [2:0] c_ALU_SUB  = 3'b110;
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                 r_state;
   state_t                 w_next;
   logic [CNT_WIDTH-1:0]   r_cycle_count;
   logic [CNT_WIDTH-1:0]   r_instr_count;
   logic                   w_rdy;
   logic                   w_func_ok;
   logic [2:0]             w_func_alu;
   logic                   w_mem_req, w_mem_write, w_pc_enable, w_instr_write, w_reg_write;

   assign w_rdy = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

   always_comb begin
      w_func_ok  = 1'b1;
      w_func_alu = c_ALU_ADD;
      case (func)
         6'b100000: w_func_alu = c_ALU_ADD;
         6'b100010: w_func_alu = c_ALU_SUB;
         6'b100100: w_func_alu = 3'b000;
         6'b100101: w_func_alu = 3'b001;
         6'b101010: w_func_alu = 3'b111;
         default:   w_func_ok  = 1'b0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:   if (w_rdy) w_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               c_OP_LW, c_OP_SW: w_next = S_MEMADR;
               c_OP_RTYPE:       w_next = w_func_ok ? S_RTYPEEX : S_TRAP;
               c_OP_BEQ:         w_next = S_BEQEX;
               c_OP_BNE:         w_next = (SUPPORT_BNE  != 0) ? S_BNEEX  : S_TRAP;
               c_OP_ADDI:        w_next = (SUPPORT_ADDI != 0) ? S_ADDIEX : S_TRAP;
               c_OP_J:           w_next = (SUPPORT_JUMP != 0) ? S_JEX    : S_TRAP;
               default:          w_next = S_TRAP;
            endcase
         end
         S_MEMADR:  w_next = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (w_rdy) w_next = S_MEMWB;
         S_MEMWR:   if (w_rdy) w_next = S_FETCH;
         S_RTYPEEX: w_next = S_RTYPEWB;
         S_ADDIEX:  w_next = S_ADDIWB;
         S_MEMWB, S_RTYPEWB, S_BEQEX, S_BNEEX, S_ADDIWB, S_JEX: w_next = S_FETCH;
         S_TRAP:    w_next = S_TRAP;
         default:   w_next = S_TRAP;
      endcase
   end

   always_comb begin
      w_mem_req      = 1'b0;
      w_mem_write    = 1'b0;
      w_pc_enable    = 1'b0;
      w_instr_write  = 1'b0;
      w_reg_write    = 1'b0;
      iord           = 1'b0;
      alu_src_a      = 1'b0;
      alu_src_b      = 2'b00;
      mem_to_reg_sel = 1'b0;
      reg_dest       = 1'b0;
      pc_source      = 2'b00;
      alu_control    = c_ALU_ADD;
      illegal_op     = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req     = 1'b1;
            alu_src_b     = 2'b01;
            w_instr_write = w_rdy;
            w_pc_enable   = w_rdy;
         end
         S_DECODE:  alu_src_b = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            w_mem_req = 1'b1;
            iord      = 1'b1;
         end
         S_MEMWB: begin
            w_reg_write    = 1'b1;
            mem_to_reg_sel = 1'b1;
         end
         S_MEMWR: begin
            w_mem_req   = 1'b1;
            w_mem_write = 1'b1;
            iord        = 1'b1;
         end
         S_RTYPEEX: begin
            alu_src_a   = 1'b1;
            alu_control = w_func_alu;
         end
         S_RTYPEWB: begin
            w_reg_write = 1'b1;
            reg_dest    = 1'b1;
         end
         S_BEQEX, S_BNEEX: begin
            alu_src_a   = 1'b1;
            alu_control = c_ALU_SUB;
            pc_source   = 2'b01;
            w_pc_enable = (r_state == S_BEQEX) ? zero_flag : ~zero_flag;
         end
         S_ADDIWB:  w_reg_write = 1'b1;
         S_JEX: begin
            w_pc_enable = 1'b1;
            pc_source   = 2'b10;
         end
         S_TRAP:    illegal_op = 1'b1;
         default:   illegal_op = 1'b1;
      endcase
   end

   // Strobes are qualified by reset directly so an abort drops them without waiting for a clock.
   assign mem_req     = w_mem_req     & reset;
   assign mem_write   = w_mem_write   & reset;
   assign pc_enable   = w_pc_enable   & reset;
   assign instr_write = w_instr_write & reset;
   assign reg_write   = w_reg_write   & reset;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= S_FETCH;
         r_cycle_count <= '0;
         r_instr_count <= '0;
      end else begin
         r_state       <= w_next;
         r_cycle_count <= r_cycle_count + c_CNT_ONE;
         if ((w_next == S_FETCH) && (r_state != S_FETCH))
            r_instr_count <= r_instr_count + c_CNT_ONE;
      end
   end

   assign cycle_count = r_cycle_count;
   assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_controller
// Brief    : Randomized scoreboard bench for two controller configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_controller;

   // Instance 0: full feature set with handshake; instance 1: no handshake, no optional ops.
   localparam logic [1:0] HS = 2'b01;
   localparam logic [1:0] SA = 2'b01;
   localparam logic [1:0] SJ = 2'b01;
   localparam logic [1:0] SB = 2'b01;

   typedef struct packed {
      logic       mem_req, mem_write, iord, pc_enable, instr_write, reg_write, alu_src_a;
      logic [1:0] alu_src_b;
      logic       mem_to_reg_sel, reg_dest;
      logic [1:0] pc_source;
      logic [2:0] alu_control;
      logic       illegal_op;
   } ctrl_t;

   typedef struct packed {
      ctrl_t      c;
      logic [7:0] cyc;
      logic [7:0] ins;
   } exp_t;

   logic       clock = 1'b0;
   logic       rst [2];
   logic [5:0] opcode [2];
   logic [5:0] func [2];
   logic       zero_flag [2];
   logic       mem_ready [2];
   logic       mem_req [2], mem_write [2], iord [2], pc_enable [2], instr_write [2];
   logic       reg_write [2], alu_src_a [2], mem_to_reg_sel [2], reg_dest [2], illegal_op [2];
   logic [1:0] alu_src_b [2], pc_source [2];
   logic [2:0] alu_control [2];
   logic [7:0] cycle_count [2], instr_count [2];

   exp_t       sb [2][$];
   logic [7:0] cyc_m [2];
   logic [7:0] ins_m [2];
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mips_mc_controller #(
         .MEM_HANDSHAKE(int'(HS[g])), .SUPPORT_ADDI(int'(SA[g])),
         .SUPPORT_JUMP(int'(SJ[g])),  .SUPPORT_BNE(int'(SB[g])), .CNT_WIDTH(8)
      ) u_dut (
         .clock(clock), .reset(rst[g]), .opcode(opcode[g]), .func(func[g]),
         .zero_flag(zero_flag[g]), .mem_ready(mem_ready[g]),
         .mem_req(mem_req[g]), .mem_write(mem_write[g]), .iord(iord[g]),
         .pc_enable(pc_enable[g]), .instr_write(instr_write[g]), .reg_write(reg_write[g]),
         .alu_src_a(alu_src_a[g]), .alu_src_b(alu_src_b[g]), .mem_to_reg_sel(mem_to_reg_sel[g]),
         .reg_dest(reg_dest[g]), .pc_source(pc_source[g]), .alu_control(alu_control[g]),
         .illegal_op(illegal_op[g]), .cycle_count(cycle_count[g]), .instr_count(instr_count[g])
      );
   end

   function automatic ctrl_t base();
      ctrl_t c = '0;
      c.alu_control = 3'b010;
      return c;
   endfunction

   function automatic bit func_ok(input logic [5:0] f);
      return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic bit known_op(input logic [5:0] o);
      return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
   endfunction

   // kinds: 0 R, 1 lw, 2 sw, 3 beq, 4 bne, 5 addi, 6 j, 7 illegal encoding
   function automatic bit kind_ok(input int d, input int k);
      case (k)
         0, 1, 2, 3: return 1'b1;
         4:          return SB[d];
         5:          return SA[d];
         6:          return SJ[d];
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic rnd_ready(input int d);
      return HS[d] ? 1'($urandom_range(0, 1)) : 1'b0;
   endfunction

   task automatic step(input int d, input ctrl_t c, input bit retire);
      exp_t e;
      e.c = c; e.cyc = cyc_m[d]; e.ins = ins_m[d];
      sb[d].push_back(e);
      @(posedge clock);
      #1;
      if (rst[d]) cyc_m[d] = cyc_m[d] + 8'd1;
      if (retire) ins_m[d] = ins_m[d] + 8'd1;
   endtask

   task automatic do_reset(input int d, input int n);
      ctrl_t c;
      rst[d] = 1'b0; cyc_m[d] = 8'd0; ins_m[d] = 8'd0;
      c = base(); c.alu_src_b = 2'b01;
      for (int i = 0; i < n; i++) begin
         mem_ready[d] = 1'($urandom_range(0, 1));
         step(d, c, 1'b0);
      end
      rst[d] = 1'b1;
   endtask

   task automatic run_instr(input int d, input bit legal_only);
      int kind, wf, wm;
      bit zf, abort;
      logic [5:0] op, fn;
      ctrl_t c;
      do kind = $urandom_range(0, 7); while (legal_only && !kind_ok(d, kind));
      fn = 6'($urandom);
      case (kind)
         0: begin
            op = 6'b000000;
            case ($urandom_range(0, 4))
               0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
               3: fn = 6'b100101; default: fn = 6'b101010;
            endcase
         end
         1: op = 6'b100011;
         2: op = 6'b101011;
         3: op = 6'b000100;
         4: op = 6'b000101;
         5: op = 6'b001000;
         6: op = 6'b000010;
         default: begin
            if ($urandom_range(0, 1) == 1) begin
               op = 6'b000000;
               while (func_ok(fn)) fn = 6'($urandom);
            end else begin
               op = 6'($urandom);
               while (known_op(op)) op = 6'($urandom);
            end
         end
      endcase
      wf = HS[d] ? $urandom_range(0, 2) : 0;
      wm = HS[d] ? $urandom_range(0, 3) : 0;
      zf = 1'($urandom_range(0, 1));
      abort = !legal_only && (d == 0) && (kind == 2) && ($urandom_range(0, 2) == 0);
      if (abort) wm = 3;
      opcode[d] = op; func[d] = fn; zero_flag[d] = zf;

      for (int i = 0; i <= wf; i++) begin
         c = base(); c.mem_req = 1'b1; c.alu_src_b = 2'b01;
         c.instr_write = (i == wf); c.pc_enable = (i == wf);
         mem_ready[d] = HS[d] ? (i == wf) : 1'b0;
         step(d, c, 1'b0);
      end
      c = base(); c.alu_src_b = 2'b11;
      mem_ready[d] = rnd_ready(d);
      step(d, c, 1'b0);

      if (!kind_ok(d, kind)) begin
         int n = $urandom_range(2, 5);
         for (int i = 0; i < n; i++) begin
            c = base(); c.illegal_op = 1'b1;
            mem_ready[d] = rnd_ready(d);
            step(d, c, 1'b0);
         end
         do_reset(d, 2);
         return;
      end

      mem_ready[d] = rnd_ready(d);
      case (kind)
         0: begin
            c = base(); c.alu_src_a = 1'b1; c.alu_control = alu_of(fn);
            step(d, c, 1'b0);
            c = base(); c.reg_write = 1'b1; c.reg_dest = 1'b1;
            step(d, c, 1'b1);
         end
         1, 2: begin
            c = base(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            step(d, c, 1'b0);
            for (int i = 0; i <= wm; i++) begin
               if (abort && i == 1) begin
                  do_reset(d, 2);
                  return;
               end
               c = base(); c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = (kind == 2);
               mem_ready[d] = HS[d] ? (i == wm) : 1'b0;
               step(d, c, (kind == 2) && (i == wm));
            end
            if (kind == 1) begin
               c = base(); c.reg_write = 1'b1; c.mem_to_reg_sel = 1'b1;
               mem_ready[d] = rnd_ready(d);
               step(d, c, 1'b1);
            end
         end
         3, 4: begin
            c = base(); c.alu_src_a = 1'b1; c.alu_control = 3'b110; c.pc_source = 2'b01;
            c.pc_enable = (kind == 3) ? zf : ~zf;
            step(d, c, 1'b1);
         end
         5: begin
            c = base(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            step(d, c, 1'b0);
            c = base(); c.reg_write = 1'b1;
            step(d, c, 1'b1);
         end
         default: begin
            c = base(); c.pc_enable = 1'b1; c.pc_source = 2'b10;
            step(d, c, 1'b1);
         end
      endcase
   endtask

   task automatic stream(input int d);
      @(posedge clock);
      #1;
      do_reset(d, 3);
      for (int i = 0; i < 80; i++)  run_instr(d, 1'b1);
      for (int i = 0; i < 150; i++) run_instr(d, 1'b0);
   endtask

   always @(negedge clock) begin
      exp_t  x;
      ctrl_t a;
      for (int d = 0; d < 2; d++) begin
         if (sb[d].size() != 0) begin
            x = sb[d].pop_front();
            a.mem_req = mem_req[d];           a.mem_write = mem_write[d];
            a.iord = iord[d];                 a.pc_enable = pc_enable[d];
            a.instr_write = instr_write[d];   a.reg_write = reg_write[d];
            a.alu_src_a = alu_src_a[d];       a.alu_src_b = alu_src_b[d];
            a.mem_to_reg_sel = mem_to_reg_sel[d]; a.reg_dest = reg_dest[d];
            a.pc_source = pc_source[d];       a.alu_control = alu_control[d];
            a.illegal_op = illegal_op[d];
            n_checks++;
            if (a !== x.c) begin
               n_fail++;
               $display("FAIL ctrl dut%0d t=%0t actual=%h required=%h", d, $time, a, x.c);
            end
            n_checks++;
            if ({cycle_count[d], instr_count[d]} !== {x.cyc, x.ins}) begin
               n_fail++;
               $display("FAIL counters dut%0d t=%0t actual cyc=%0d ins=%0d required cyc=%0d ins=%0d",
                        d, $time, cycle_count[d], instr_count[d], x.cyc, x.ins);
            end
         end
      end
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; opcode[d] = '0; func[d] = '0; zero_flag[d] = 1'b0;
         mem_ready[d] = 1'b0; cyc_m[d] = '0; ins_m[d] = '0;
      end
      fork
         stream(0);
         stream(1);
      join
      @(negedge clock);
      n_checks++;
      if (sb[0].size() + sb[1].size() != 0) begin
         n_fail++;
         $display("FAIL drain actual=%0d required=0", sb[0].size() + sb[1].size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
